// File: rtl/y_compactor_pkg.sv
// y_compactor_pkg
// Definitions shared by the y_compactor slice:
//   - state_t        : FSM state encoding (IDLE / RUN / DONE)
//   - DEFAULT_POLY   : default MISR feedback polynomial (CRC-32 taps)
//   - DEFAULT_SEED   : default MISR seed loaded on start
//   - chunk_count()  : number of SIG_W-wide chunks covering a DATA_W vector
package y_compactor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEFAULT_SEED = 32'hFFFFFFFF;

    // Ceiling division, used to size the zero-padded fold input.
    function automatic int chunk_count(input int data_w, input int sig_w);
        return (data_w + sig_w - 1) / sig_w;
    endfunction

endpackage

// File: rtl/y_fold.sv
// y_fold
// Purely combinational XOR fold of a wide vector into SIG_W bits.
// The input is zero-padded up to a whole number of SIG_W chunks and
// all chunks are XORed together.
//   data [DATA_W-1:0] : wide input vector
//   fold [SIG_W-1:0]  : XOR of all SIG_W-wide chunks
module y_fold
    import y_compactor_pkg::*;
#(
    parameter int DATA_W = 635,
    parameter int SIG_W  = 32
) (
    input  logic [DATA_W-1:0] data,
    output logic [SIG_W-1:0]  fold
);

    localparam int NCHUNK = chunk_count(DATA_W, SIG_W);
    localparam int PAD_W  = NCHUNK * SIG_W;

    logic [PAD_W-1:0] padded;

    // Zero-extend to a whole number of chunks, then XOR every chunk
    // together. The top chunk is only partially populated; its upper
    // bits are the zero padding.
    always_comb begin
        padded = PAD_W'(data);
        fold   = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            fold = fold ^ padded[k*SIG_W +: SIG_W];
        end
    end

endmodule

// File: rtl/y_compactor.sv
// y_compactor
// Folds the per-cycle y vector of the design under test and shifts it
// into a MISR. After NUM_SAMPLES accepted samples the MISR contents are
// published as a single compact signature.
// Optional feature macro: Y_COMPACTOR_EXPECT_EN (adds EXPECT_SIG / match).
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : pulse that begins or restarts a run (wins over in_valid)
//   in_valid   : in_data carries a sample this cycle
//   in_data    : y vector, DATA_W bits
//   busy       : high while a run is in progress
//   sample_cnt : samples absorbed in the current run
//   sig_valid  : signature is final
//   signature  : MISR contents
//   match      : (macro only) final signature equals EXPECT_SIG
module y_compactor
    import y_compactor_pkg::*;
#(
    parameter int               DATA_W      = 635,
    parameter int               SIG_W       = 32,
    parameter logic [SIG_W-1:0] POLY        = DEFAULT_POLY,
    parameter logic [SIG_W-1:0] SEED        = DEFAULT_SEED,
    parameter int               NUM_SAMPLES = 21,
    parameter int               CNT_W       = 16
`ifdef Y_COMPACTOR_EXPECT_EN
    ,
    parameter logic [SIG_W-1:0] EXPECT_SIG  = '0
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic              sig_valid,
    output logic [SIG_W-1:0]  signature
`ifdef Y_COMPACTOR_EXPECT_EN
    ,
    output logic              match
`endif
);

    state_t           state_q, state_d;
    logic [SIG_W-1:0] sig_d;
    logic [CNT_W-1:0] cnt_d;
    logic [SIG_W-1:0] fold;
    logic [SIG_W-1:0] misr_next;
    logic             last_sample;
`ifdef Y_COMPACTOR_EXPECT_EN
    logic             match_d;
`endif

    y_fold #(
        .DATA_W (DATA_W),
        .SIG_W  (SIG_W)
    ) u_fold (
        .data (in_data),
        .fold (fold)
    );

    // One MISR step: shift left, apply polynomial feedback when the bit
    // shifted out was set, and inject the folded sample.
    always_comb begin
        misr_next   = {signature[SIG_W-2:0], 1'b0}
                    ^ (signature[SIG_W-1] ? POLY : '0)
                    ^ fold;
        last_sample = (sample_cnt == CNT_W'(NUM_SAMPLES - 1));
    end

    // Next-state logic. start overrides everything, so a sample that
    // arrives together with start is never absorbed. Only RUN reacts to
    // in_valid; IDLE and DONE hold their state until the next start.
    always_comb begin
        state_d = state_q;
        sig_d   = signature;
        cnt_d   = sample_cnt;
`ifdef Y_COMPACTOR_EXPECT_EN
        match_d = match;
`endif
        if (start) begin
            state_d = RUN;
            sig_d   = SEED;
            cnt_d   = '0;
`ifdef Y_COMPACTOR_EXPECT_EN
            match_d = 1'b0;
`endif
        end else begin
            case (state_q)
                RUN: begin
                    if (in_valid) begin
                        sig_d = misr_next;
                        cnt_d = sample_cnt + CNT_W'(1);
                        if (last_sample) begin
                            state_d = DONE;
`ifdef Y_COMPACTOR_EXPECT_EN
                            match_d = (misr_next == EXPECT_SIG);
`endif
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers. busy and sig_valid are registered from
    // the next state so they change on the same edge as the transition,
    // with no combinational path from the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            signature  <= '0;
            sample_cnt <= '0;
            busy       <= 1'b0;
            sig_valid  <= 1'b0;
        end else begin
            state_q    <= state_d;
            signature  <= sig_d;
            sample_cnt <= cnt_d;
            busy       <= (state_d == RUN);
            sig_valid  <= (state_d == DONE);
        end
    end

`ifdef Y_COMPACTOR_EXPECT_EN
    // Compare flag, updated on the edge that accepts the final sample and
    // cleared by start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match <= 1'b0;
        end else begin
            match <= match_d;
        end
    end
`endif

endmodule

// File: tb/tb_y_compactor.sv
// tb_y_compactor
// Directed self-checking bench for y_compactor. Several instances share
// one stimulus stream:
//   dut_a : NUM_SAMPLES=1, default seed        (null-input signature)
//   dut_b : NUM_SAMPLES=1, SEED=0              (fold bit positions)
//   dut_c : defaults, NUM_SAMPLES=21           (full run, restart, reset)
//   dut_e : NUM_SAMPLES=1, EXPECT_SIG=0        (mismatching expect value)
module tb_y_compactor;

    localparam int DW = 635;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;

    logic          a_busy, b_busy, c_busy, e_busy;
    logic [15:0]   a_cnt, b_cnt, c_cnt, e_cnt;
    logic          a_sv, b_sv, c_sv, e_sv;
    logic [31:0]   a_sig, b_sig, c_sig, e_sig;
`ifdef Y_COMPACTOR_EXPECT_EN
    logic          a_match, b_match, c_match, e_match;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    y_compactor #(
        .NUM_SAMPLES (1)
`ifdef Y_COMPACTOR_EXPECT_EN
        , .EXPECT_SIG (32'hFB3EE249)
`endif
    ) dut_a (
        .clk (clk), .rst_n (rst_n), .start (start), .in_valid (in_valid),
        .in_data (in_data), .busy (a_busy), .sample_cnt (a_cnt),
        .sig_valid (a_sv), .signature (a_sig)
`ifdef Y_COMPACTOR_EXPECT_EN
        , .match (a_match)
`endif
    );

    y_compactor #(
        .SEED (32'h0),
        .NUM_SAMPLES (1)
    ) dut_b (
        .clk (clk), .rst_n (rst_n), .start (start), .in_valid (in_valid),
        .in_data (in_data), .busy (b_busy), .sample_cnt (b_cnt),
        .sig_valid (b_sv), .signature (b_sig)
`ifdef Y_COMPACTOR_EXPECT_EN
        , .match (b_match)
`endif
    );

    y_compactor dut_c (
        .clk (clk), .rst_n (rst_n), .start (start), .in_valid (in_valid),
        .in_data (in_data), .busy (c_busy), .sample_cnt (c_cnt),
        .sig_valid (c_sv), .signature (c_sig)
`ifdef Y_COMPACTOR_EXPECT_EN
        , .match (c_match)
`endif
    );

    y_compactor #(
        .NUM_SAMPLES (1)
`ifdef Y_COMPACTOR_EXPECT_EN
        , .EXPECT_SIG (32'h0)
`endif
    ) dut_e (
        .clk (clk), .rst_n (rst_n), .start (start), .in_valid (in_valid),
        .in_data (in_data), .busy (e_busy), .sample_cnt (e_cnt),
        .sig_valid (e_sv), .signature (e_sig)
`ifdef Y_COMPACTOR_EXPECT_EN
        , .match (e_match)
`endif
    );

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then step to just
    // after the rising edge that consumes them.
    task automatic applyStimulus(input logic s, input logic v,
                                 input logic [DW-1:0] d);
        @(negedge clk);
        start    = s;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    // Deterministic pseudo-y vector for sample k.
    function automatic logic [DW-1:0] make_y(input int k);
        logic [DW-1:0] v;
        for (int i = 0; i < DW; i++) begin
            v[i] = (((i * 7 + k * 13) % 5) == 0) ^ (((i + k) % 3) == 1);
        end
        return v;
    endfunction

    // Reference MISR step: each input bit i lands on signature bit i%32.
    function automatic logic [31:0] model_step(input logic [31:0] s,
                                               input logic [DW-1:0] d);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < DW; i++) begin
            f[i % 32] = f[i % 32] ^ d[i];
        end
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
    endfunction

    logic [DW-1:0] vec;
    logic [31:0]   model;
    logic [31:0]   held;

    initial begin
        // Reset state
        #12;
        checkOutput("reset_busy", 64'(c_busy), 64'd0);
        checkOutput("reset_cnt", 64'(c_cnt), 64'd0);
        checkOutput("reset_sig_valid", 64'(c_sv), 64'd0);
        checkOutput("reset_sig", 64'(c_sig), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE ignores in_valid
        applyStimulus(1'b0, 1'b1, make_y(0));
        checkOutput("idle_ignore_cnt", 64'(c_cnt), 64'd0);
        checkOutput("idle_ignore_busy", 64'(c_busy), 64'd0);

        // Start loads seed
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("start_busy", 64'(c_busy), 64'd1);
        checkOutput("start_sig", 64'(c_sig), 64'hFFFFFFFF);
        checkOutput("start_seed0", 64'(b_sig), 64'h0);

        // Null-input single sample
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("null_sig", 64'(a_sig), 64'hFB3EE249);
        checkOutput("null_sig_valid", 64'(a_sv), 64'd1);
        checkOutput("null_cnt", 64'(a_cnt), 64'd1);
        checkOutput("null_busy", 64'(a_busy), 64'd0);
        checkOutput("null_long_busy", 64'(c_busy), 64'd1);
`ifdef Y_COMPACTOR_EXPECT_EN
        checkOutput("match_hit", 64'(a_match), 64'd1);
        checkOutput("match_miss", 64'(e_match), 64'd0);
`endif

        // Fold position: bit 0
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("restart_sig_valid", 64'(a_sv), 64'd0);
`ifdef Y_COMPACTOR_EXPECT_EN
        checkOutput("match_cleared", 64'(a_match), 64'd0);
`endif
        vec = '0;
        vec[0] = 1'b1;
        applyStimulus(1'b0, 1'b1, vec);
        checkOutput("fold_bit0", 64'(b_sig), 64'h00000001);

        // Fold position: bit 634
        applyStimulus(1'b1, 1'b0, '0);
        vec = '0;
        vec[634] = 1'b1;
        applyStimulus(1'b0, 1'b1, vec);
        checkOutput("fold_bit634", 64'(b_sig), 64'h04000000);

        // Full run with stalls, then the same run without stalls
        for (int pass = 0; pass < 2; pass++) begin
            applyStimulus(1'b1, 1'b0, '0);
            model = 32'hFFFFFFFF;
            for (int k = 0; k < 21; k++) begin
                if (pass == 0 && (k % 3) == 1) begin
                    applyStimulus(1'b0, 1'b0, ~make_y(k));
                    applyStimulus(1'b0, 1'b0, make_y(k + 50));
                end
                applyStimulus(1'b0, 1'b1, make_y(k));
                model = model_step(model, make_y(k));
            end
            checkOutput("full_sig", 64'(c_sig), 64'(model));
            checkOutput("full_cnt", 64'(c_cnt), 64'd21);
            checkOutput("full_sig_valid", 64'(c_sv), 64'd1);
            checkOutput("full_busy", 64'(c_busy), 64'd0);
        end

        // DONE holds signature and count, ignores in_valid
        held = c_sig;
        applyStimulus(1'b0, 1'b1, make_y(3));
        applyStimulus(1'b0, 1'b1, make_y(4));
        checkOutput("done_hold_sig", 64'(c_sig), 64'(held));
        checkOutput("done_hold_cnt", 64'(c_cnt), 64'd21);

        // Start collides with in_valid: sample not absorbed
        applyStimulus(1'b1, 1'b1, make_y(7));
        checkOutput("collide_cnt", 64'(c_cnt), 64'd0);
        checkOutput("collide_sig", 64'(c_sig), 64'hFFFFFFFF);
        checkOutput("collide_sig_valid", 64'(c_sv), 64'd0);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, make_y(k));
        checkOutput("five_cnt", 64'(c_cnt), 64'd5);
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("restart_cnt", 64'(c_cnt), 64'd0);
        checkOutput("restart_sig", 64'(c_sig), 64'hFFFFFFFF);
        checkOutput("restart_busy", 64'(c_busy), 64'd1);

        // Reset mid-run: outputs clear before the next edge
        for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b1, make_y(k));
        checkOutput("pre_reset_cnt", 64'(c_cnt), 64'd10);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_busy", 64'(c_busy), 64'd0);
        checkOutput("async_rst_cnt", 64'(c_cnt), 64'd0);
        checkOutput("async_rst_sig", 64'(c_sig), 64'd0);
        checkOutput("async_rst_sig_valid", 64'(c_sv), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, make_y(1));
        checkOutput("post_rst_cnt", 64'(c_cnt), 64'd0);
        checkOutput("post_rst_busy", 64'(c_busy), 64'd0);
        checkOutput("post_rst_sig", 64'(c_sig), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, failures);
        $finish;
    end

endmodule
